// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester ports and the shared memory port of
// mem_port_arbiter.
//   Port A (fetch, read-only): read_a, address_a -> resp_a, rdata_a
//   Port B (data, read/write): read_b, write_b, wmask_b, address_b, wdata_b
//                              -> resp_b, rdata_b
//   Memory side: mem_read, mem_write, mem_wmask, mem_address, mem_wdata
//                <- mem_resp, mem_rdata
//   err_timeout: sticky watchdog flag from the arbiter
// Modports: slave = the arbiter, master = the environment around it.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  read_a;
    logic [ADDR_W-1:0]     address_a;
    logic                  resp_a;
    logic [DATA_W-1:0]     rdata_a;

    logic                  read_b;
    logic                  write_b;
    logic [DATA_W/8-1:0]   wmask_b;
    logic [ADDR_W-1:0]     address_b;
    logic [DATA_W-1:0]     wdata_b;
    logic                  resp_b;
    logic [DATA_W-1:0]     rdata_b;

    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic [ADDR_W-1:0]     mem_address;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_resp;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  err_timeout;

    modport slave (
        input  read_a, address_a,
        input  read_b, write_b, wmask_b, address_b, wdata_b,
        input  mem_resp, mem_rdata,
        output resp_a, rdata_a, resp_b, rdata_b,
        output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        output err_timeout
    );

    modport master (
        output read_a, address_a,
        output read_b, write_b, wmask_b, address_b, wdata_b,
        output mem_resp, mem_rdata,
        input  resp_a, rdata_a, resp_b, rdata_b,
        input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        input  err_timeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between an instruction-fetch requester (A,
// read-only) and a data requester (B, read/write). One transaction at a time,
// round-robin on ties, sticky watchdog flag when memory stops answering.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mem_port_arbiter_if.slave carrying both requester ports, the
//          memory command/response port and err_timeout
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam int WD_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                last_grant_b;

    logic                cmd_read;
    logic                cmd_write;
    logic [MASK_W-1:0]   cmd_wmask;
    logic [ADDR_W-1:0]   cmd_address;
    logic [DATA_W-1:0]   cmd_wdata;

    logic [WD_W-1:0]     wd_cnt;
    logic                err_q;

    logic                req_a;
    logic                req_b;
    logic                grant_a;
    logic                grant_b;
    logic                b_is_write;
    logic                serving;
    logic                grant_now;

    // Arbitration: on a tie the port that was not served last wins.
    always_comb begin
        req_a      = bus.read_a;
        req_b      = bus.read_b | bus.write_b;
        grant_a    = req_a & (~req_b | last_grant_b);
        grant_b    = req_b & (~req_a | ~last_grant_b);
        // read_b and write_b together are treated as a read
        b_is_write = bus.write_b & ~bus.read_b;
        serving    = (state != IDLE);
        grant_now  = (state == IDLE) & (grant_a | grant_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus all outputs; memory command comes only from the
    // command register and is forced to zero outside SERVE states.
    always_comb begin
        state_next      = state;
        bus.resp_a      = 1'b0;
        bus.resp_b      = 1'b0;
        bus.rdata_a     = '0;
        bus.rdata_b     = '0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_wmask   = '0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        bus.err_timeout = err_q;

        if (serving) begin
            bus.mem_read    = cmd_read;
            bus.mem_write   = cmd_write;
            bus.mem_wmask   = cmd_wmask;
            bus.mem_address = cmd_address;
            bus.mem_wdata   = cmd_wdata;
        end

        case (state)
            IDLE: begin
                // mem_resp is deliberately ignored here
                if (grant_a) begin
                    state_next = SERVE_A;
                end else if (grant_b) begin
                    state_next = SERVE_B;
                end
            end
            SERVE_A: begin
                if (bus.mem_resp) begin
                    bus.resp_a  = 1'b1;
                    bus.rdata_a = bus.mem_rdata;
                    state_next  = IDLE;
                end
            end
            SERVE_B: begin
                if (bus.mem_resp) begin
                    bus.resp_b  = 1'b1;
                    bus.rdata_b = bus.mem_rdata;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control side of the command register, fairness pointer and watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_b <= 1'b1;
            cmd_read     <= 1'b0;
            cmd_write    <= 1'b0;
            wd_cnt       <= '0;
            err_q        <= 1'b0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
            if (grant_now) begin
                last_grant_b <= grant_b;
                cmd_read     <= grant_a | bus.read_b;
                cmd_write    <= grant_b & b_is_write;
            end
        end else if (!bus.mem_resp) begin
            if (wd_cnt != WD_W'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            // set on the edge where the count reaches TIMEOUT
            if (wd_cnt >= WD_W'(TIMEOUT - 1)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Data side of the command register: captured only at grant, so
    // requester changes during service cannot leak onto the memory bus.
    always_ff @(posedge clk) begin
        if (grant_now) begin
            cmd_address <= grant_a ? bus.address_a : bus.address_b;
            cmd_wmask   <= (grant_b & b_is_write) ? bus.wmask_b : '0;
            cmd_wdata   <= (grant_b & b_is_write) ? bus.wdata_b : '0;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed stimulus with a response scoreboard: each issued transaction pushes
// its expected completing port and read data; a monitor pops and compares on
// every resp_a/resp_b pulse. A small memory responder answers commands after
// a programmable latency.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int TO = 8;

    typedef struct {
        bit          pb;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat    = 2;
    bit   hold   = 0;
    bit   poke   = 0;
    bit   post   = 0;
    int   rcnt   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] addr);
        return (addr == 32'h100) ? 32'hDEADBEEF : (addr ^ 32'h5A5A0000);
    endfunction

    // Memory responder: answers once a command has been up for lat cycles.
    always @(posedge clk) begin
        #1;
        if (bus.mem_read || bus.mem_write) begin
            rcnt++;
            if (rcnt >= lat && !hold) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = bus.mem_read ? model(bus.mem_address) : 32'h0;
            end else begin
                bus.mem_resp  = 1'b0;
                bus.mem_rdata = 32'h0;
            end
        end else begin
            rcnt          = 0;
            bus.mem_resp  = poke;
            bus.mem_rdata = poke ? 32'hBAD0BAD0 : 32'h0;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (post) begin
            chk("idle_gap_cmd", {bus.mem_read, bus.mem_write, bus.mem_wmask}, 0);
            chk("idle_gap_addr", bus.mem_address, 0);
            post = 0;
        end
        if (bus.resp_a || bus.resp_b) begin
            chk("sb_single_resp", bus.resp_a & bus.resp_b, 0);
            if (sb.size() == 0) begin
                chk("sb_unexpected_resp", {bus.resp_a, bus.resp_b}, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_port", bus.resp_b, e.pb);
                chk("sb_rdata", bus.resp_b ? bus.rdata_b : bus.rdata_a, e.data);
            end
            post = 1;
        end
        chk("rdata_quiet", {(bus.resp_a ? 32'h0 : bus.rdata_a), (bus.resp_b ? 32'h0 : bus.rdata_b)}, 0);
    end

    // One requester transaction; starts and ends just after a rising edge.
    task automatic req(input bit pb, input bit push, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [3:0] m,
                       input logic [31:0] d, input logic [31:0] exp);
        bit got = 0;
        if (push) sb.push_back('{pb, exp});
        if (!pb) begin
            bus.read_a    = 1'b1;
            bus.address_a = addr;
        end else begin
            bus.read_b    = rd;
            bus.write_b   = wr;
            bus.address_b = addr;
            bus.wmask_b   = m;
            bus.wdata_b   = d;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pb ? bus.resp_b : bus.resp_a) begin
                got = 1;
                break;
            end
        end
        if (!got) chk(pb ? "resp_b_timeout" : "resp_a_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!pb) bus.read_a = 1'b0;
        else begin
            bus.read_b  = 1'b0;
            bus.write_b = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit got;
        rst = 1'b1;
        bus.read_a = 0; bus.address_a = 0;
        bus.read_b = 0; bus.write_b = 0; bus.wmask_b = 0;
        bus.address_b = 0; bus.wdata_b = 0;
        bus.mem_resp = 0; bus.mem_rdata = 0;

        // reset state
        @(negedge clk);
        chk("rst_mem_cmd", {bus.mem_read, bus.mem_write, bus.mem_wmask}, 0);
        chk("rst_mem_addr_data", {bus.mem_address, bus.mem_wdata}, 0);
        chk("rst_resp", {bus.resp_a, bus.resp_b}, 0);
        chk("rst_err", bus.err_timeout, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // both ports from reset: A, B, A, B
        sb.push_back('{1'b0, 32'h5A5A0104});
        sb.push_back('{1'b1, 32'h5A5A0204});
        sb.push_back('{1'b0, 32'h5A5A0108});
        sb.push_back('{1'b1, 32'h5A5A0208});
        fork
            begin
                for (int i = 0; i < 2; i++) req(0, 0, 1, 0, 32'h104 + 4 * i, 0, 0, 0);
            end
            begin
                for (int j = 0; j < 2; j++) req(1, 0, 1, 0, 32'h204 + 4 * j, 0, 0, 0);
            end
        join
        @(posedge clk); #1;

        // single A read
        fork
            req(0, 1, 1, 0, 32'h100, 0, 0, 32'hDEADBEEF);
            begin
                @(negedge clk);
                chk("t1_latency", bus.mem_read, 0);
                @(negedge clk);
                chk("t1_mem_read", {bus.mem_read, bus.mem_write}, 2'b10);
                chk("t1_mem_addr", bus.mem_address, 32'h100);
            end
        join

        // B write
        fork
            req(1, 1, 0, 1, 32'h200, 4'b0101, 32'h11223344, 32'h0);
            begin
                @(negedge clk);
                chk("t2_latency", {bus.mem_read, bus.mem_write}, 0);
                repeat (2) begin
                    @(negedge clk);
                    chk("t2_cmd", {bus.mem_read, bus.mem_write, bus.mem_wmask}, 6'b010101);
                    chk("t2_addr_data", {bus.mem_address, bus.mem_wdata}, {32'h200, 32'h11223344});
                end
            end
        join

        // B with read and write both high: read wins
        fork
            req(1, 1, 1, 1, 32'h210, 4'hF, 32'hFFFFFFFF, 32'h5A5A0210);
            begin
                @(negedge clk);
                @(negedge clk);
                chk("t2b_cmd", {bus.mem_read, bus.mem_write, bus.mem_wmask}, 6'b100000);
                chk("t2b_wdata", bus.mem_wdata, 0);
            end
        join

        // B inputs change during service
        lat = 4;
        fork
            req(1, 1, 0, 1, 32'h300, 4'hF, 32'hCAFEF00D, 32'h0);
            begin
                @(posedge clk);
                #2;
                bus.address_b = 32'h3FC;
                bus.wdata_b   = 32'h0;
                repeat (4) begin
                    @(negedge clk);
                    chk("t4_hold", {bus.mem_address, bus.mem_wdata}, {32'h300, 32'hCAFEF00D});
                end
            end
        join
        lat = 2;

        // mem_resp while idle is ignored
        @(negedge clk);
        poke = 1;
        @(negedge clk);
        chk("idle_resp_ignored", {bus.resp_a, bus.resp_b, bus.mem_read, bus.mem_write}, 0);
        poke = 0;
        @(posedge clk); #1;

        // watchdog
        hold = 1;
        sb.push_back('{1'b0, 32'h5A5A0400});
        bus.read_a = 1; bus.address_a = 32'h400;
        @(posedge clk);
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        chk("t5_err_before", bus.err_timeout, 0);
        @(posedge clk);
        @(negedge clk);
        chk("t5_err_at_timeout", bus.err_timeout, 1);
        chk("t5_still_serving", bus.mem_read, 1);
        hold = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_a) begin
                got = 1;
                break;
            end
        end
        chk("t5_late_resp", got, 1);
        @(posedge clk); #1;
        bus.read_a = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t5_err_sticky", bus.err_timeout, 1);
        @(posedge clk); #1;

        // reset in the middle of SERVE_A
        hold = 1;
        bus.read_a = 1; bus.address_a = 32'h500;
        @(posedge clk);
        @(negedge clk);
        chk("t6_serving", bus.mem_read, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_drop", {bus.mem_read, bus.mem_address}, 0);
        bus.read_a = 0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        hold = 0;
        @(negedge clk);
        chk("t6_err_cleared", bus.err_timeout, 0);
        @(posedge clk); #1;
        sb.push_back('{1'b0, 32'h5A5A0600});
        sb.push_back('{1'b1, 32'h5A5A0700});
        fork
            req(0, 0, 1, 0, 32'h600, 0, 0, 0);
            req(1, 0, 1, 0, 32'h700, 0, 0, 0);
        join
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
